hbm_cmd_unpacker: RTL and testbench
===================================

Name: hbm_cmd_unpacker

Overview:
- Sits directly downstream of the 4-slot command generator's output FIFO, in the dfi clock domain (2x the fabric clock).
- Pops one 128-bit command entry plus its write data per FIFO read and emits it as two beats of two commands each toward the HBM adapter.
- Enforces a programmable idle gap whenever the target HBM channel changes.
- Sustains one beat per cycle so four commands per fabric cycle are preserved.

Parameters:
- HBM_CH_WIDTH, 3, channel id bits per slot
- PC_WIDTH, 1, pseudo-channel bits per slot
- BA_ADDR_WIDTH, 4, bank-group+bank bits per slot
- COL_ADDR_WIDTH, 6, column bits per slot
- ROW_ADDR_WIDTH, 14, row bits per slot
- CMD_TYPE_WIDTH, 4, command code bits per slot (per-slot sum must be 32)
- CH_SWITCH_GAP, 4, idle cycles inserted before a beat targeting a new channel; 0 disables

Ports:
- clk  in  1  dfi clock
- rst  in  1  reset, asynchronous, active-high
- fifo_data  in  128  FWFT command entry; [127:64] = slots 0,1; [63:0] = slots 2,3
- fifo_wrdata  in  1024  write data; only [511:0] used ([1023:512] is a duplicate)
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop strobe, one cycle per entry
- out_valid  out  1  beat valid
- out_ready  in  1  adapter accepts beat
- out_cmd_type  out  2*CMD_TYPE_WIDTH  [low] = first slot of beat, [high] = second
- out_row  out  2*ROW_ADDR_WIDTH  same slot ordering
- out_col  out  2*COL_ADDR_WIDTH
- out_ba  out  2*BA_ADDR_WIDTH
- out_pc  out  2*PC_WIDTH
- out_ch  out  HBM_CH_WIDTH  channel for this beat
- out_wdata  out  256  beat write data
- beat_cnt  out  32  accepted beats, wraps

Behaviour:
- Half layout, MSB→LSB: {ch[2], pc[2], ba[2], col[2], row[2], cmd[2]}. Each field pair holds the lower-index slot in its low bits.
- Entry capture: fifo_rd_en=1 in the cycle where fifo_empty=0 and (state=IDLE, or state=BEAT1 with out_valid&out_ready).
  - fifo_data and fifo_wrdata[511:0] latch into a hold register on that edge.
  - Never pop while a held entry has un-accepted beats.
- States: IDLE, GAP, BEAT0, BEAT1.
  - On capture: if captured channel (upper half, slot-0 ch field) != cur_ch and CH_SWITCH_GAP>0, go to GAP with counter=CH_SWITCH_GAP-1; otherwise go to BEAT0.
  - GAP: out_valid=0; decrement each cycle; at 0 go to BEAT0.
  - BEAT0: out_valid=1, fields from upper half, out_wdata=held[255:0]. On accept, cur_ch<=out_ch and go to BEAT1.
  - BEAT1: fields from lower half, out_wdata=held[511:256], out_ch=held channel (lower-half ch fields ignored).
    - On accept with FIFO non-empty: capture next entry (same transition rules).
    - On accept with FIFO empty: go to IDLE.
- Latency: pop in cycle N → out_valid in N+1 (no gap), or N+1+CH_SWITCH_GAP (gap).
- Throughput: back-to-back entries with no channel change give continuous out_valid.
- Handshake: while out_valid=1 and out_ready=0, all out_* fields hold stable. out_valid never drops without an accept.
- beat_cnt increments by 1 per accepted beat and wraps 0xFFFFFFFF→0.
- NOP/all-ones command codes pass through unchanged and count as beats; there is no filtering.
- Reset (async, any state including mid-entry):
  - state=IDLE, fifo_rd_en=0, out_valid=0.
  - out_cmd_type all-ones; all other out_* fields 0.
  - cur_ch=0, beat_cnt=0, gap counter=0.
  - Held entry discarded.

Test Plan:
- Reset release, push one entry on channel 0 (upper cmd {RD,ACT}, lower {NOP,PRE}, wdata[511:0]=pattern P), out_ready=1 → fifo_rd_en one pulse; BEAT0 next cycle with cmd/wdata=P[255:0]; BEAT1 with P[511:256]; beat_cnt=2; no gap.
- Three entries queued, all channel 0, out_ready=1 → 6 consecutive valid cycles; pops in cycles 0, 2, 4; beat_cnt=6.
- Entry on channel 5 after channel 0, CH_SWITCH_GAP=4 → out_valid low exactly 4 cycles, then BEAT0 with out_ch=5; rerun with CH_SWITCH_GAP=0 → no gap.
- out_ready low for 3 cycles during BEAT0 and during BEAT1 → outputs stable; no extra pop; beats not duplicated or lost.
- Assert rst in BEAT1 with FIFO non-empty → immediately out_valid=0, cmd all-ones, beat_cnt=0; after release, a channel-5 entry incurs a gap (cur_ch back to 0).
- beat_cnt forced to 0xFFFFFFFF, one beat accepted → 0.

Source files
------------

// File: rtl/hbm_cmd_unpacker_if.sv
// Command FIFO read side and two-slot beat output of the HBM command unpacker.
// slave is the unpacker's view; master is the FIFO/adapter side driving it.
interface hbm_cmd_unpacker_if #(
  parameter int HBM_CH_WIDTH   = 3,
  parameter int PC_WIDTH       = 1,
  parameter int BA_ADDR_WIDTH  = 4,
  parameter int COL_ADDR_WIDTH = 6,
  parameter int ROW_ADDR_WIDTH = 14,
  parameter int CMD_TYPE_WIDTH = 4
);
  logic [127:0]                  fifo_data;
  logic [1023:0]                 fifo_wrdata;
  logic                          fifo_empty;
  logic                          fifo_rd_en;
  logic                          out_valid;
  logic                          out_ready;
  logic [2*CMD_TYPE_WIDTH-1:0]   out_cmd_type;
  logic [2*ROW_ADDR_WIDTH-1:0]   out_row;
  logic [2*COL_ADDR_WIDTH-1:0]   out_col;
  logic [2*BA_ADDR_WIDTH-1:0]    out_ba;
  logic [2*PC_WIDTH-1:0]         out_pc;
  logic [HBM_CH_WIDTH-1:0]       out_ch;
  logic [255:0]                  out_wdata;
  logic [31:0]                   beat_cnt;

  modport slave (
    input  fifo_data, fifo_wrdata, fifo_empty, out_ready,
    output fifo_rd_en, out_valid, out_cmd_type, out_row, out_col, out_ba,
           out_pc, out_ch, out_wdata, beat_cnt
  );

  modport master (
    output fifo_data, fifo_wrdata, fifo_empty, out_ready,
    input  fifo_rd_en, out_valid, out_cmd_type, out_row, out_col, out_ba,
           out_pc, out_ch, out_wdata, beat_cnt
  );
endinterface

// File: rtl/hbm_cmd_unpacker.sv
// Splits each 4-slot FIFO entry into two 2-slot beats; pop-to-valid is 1 cycle, plus
// CH_SWITCH_GAP idle cycles on a channel change. Outputs hold while out_ready is low.
module hbm_cmd_unpacker #(
  parameter int HBM_CH_WIDTH   = 3,
  parameter int PC_WIDTH       = 1,
  parameter int BA_ADDR_WIDTH  = 4,
  parameter int COL_ADDR_WIDTH = 6,
  parameter int ROW_ADDR_WIDTH = 14,
  parameter int CMD_TYPE_WIDTH = 4,
  parameter int CH_SWITCH_GAP  = 4
) (
  input logic clk,
  input logic rst,
  hbm_cmd_unpacker_if.slave bus
);
  localparam int CMD_LO = 0;
  localparam int ROW_LO = CMD_LO + 2*CMD_TYPE_WIDTH;
  localparam int COL_LO = ROW_LO + 2*ROW_ADDR_WIDTH;
  localparam int BA_LO  = COL_LO + 2*COL_ADDR_WIDTH;
  localparam int PC_LO  = BA_LO + 2*BA_ADDR_WIDTH;
  localparam int CH_LO  = PC_LO + 2*PC_WIDTH;
  localparam int GW     = (CH_SWITCH_GAP > 1) ? $clog2(CH_SWITCH_GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'((CH_SWITCH_GAP > 0) ? CH_SWITCH_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, GAP, BEAT0, BEAT1} state_t;

  state_t                  state;
  logic [GW-1:0]           gap_cnt;
  logic [HBM_CH_WIDTH-1:0] cur_ch;
  logic [CH_LO-1:0]        hold_lo;  // lower half minus its ignored channel fields
  logic [255:0]            hold_wd;  // second beat's write data

  logic                    accept;
  logic                    pop;
  logic                    load;
  logic [HBM_CH_WIDTH-1:0] pop_ch;
  logic [CH_LO-1:0]        ld_half;
  logic [255:0]            ld_wd;

  assign accept = bus.out_valid & bus.out_ready;
  assign pop    = !rst && !bus.fifo_empty &&
                  (state == IDLE || (state == BEAT1 && accept));
  assign load   = pop || (state == BEAT0 && accept);
  assign pop_ch = bus.fifo_data[64 + CH_LO +: HBM_CH_WIDTH];

  // A pop always stages the upper half; a BEAT0 accept stages the held lower half.
  assign ld_half = pop ? bus.fifo_data[64 +: CH_LO] : hold_lo;
  assign ld_wd   = pop ? bus.fifo_wrdata[255:0] : hold_wd;

  assign bus.fifo_rd_en = pop;

  logic unused_bits;
  assign unused_bits = ^{bus.fifo_wrdata[1023:512],
                         bus.fifo_data[127:64+CH_LO+HBM_CH_WIDTH],
                         bus.fifo_data[63:CH_LO]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      gap_cnt          <= '0;
      cur_ch           <= '0;
      hold_lo          <= '0;
      hold_wd          <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_cmd_type <= '1;
      bus.out_row      <= '0;
      bus.out_col      <= '0;
      bus.out_ba       <= '0;
      bus.out_pc       <= '0;
      bus.out_ch       <= '0;
      bus.out_wdata    <= '0;
      bus.beat_cnt     <= '0;
    end else begin
      if (accept) bus.beat_cnt <= bus.beat_cnt + 32'd1;

      if (pop) begin
        hold_lo    <= bus.fifo_data[CH_LO-1:0];
        hold_wd    <= bus.fifo_wrdata[511:256];
        bus.out_ch <= pop_ch;
        if (CH_SWITCH_GAP > 0 && pop_ch != cur_ch) begin
          state         <= GAP;
          gap_cnt       <= GAP_INIT;
          bus.out_valid <= 1'b0;
        end else begin
          state         <= BEAT0;
          bus.out_valid <= 1'b1;
        end
      end else begin
        case (state)
          GAP: begin
            if (gap_cnt == '0) begin
              state         <= BEAT0;
              bus.out_valid <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - GW'(1);
            end
          end
          BEAT0: begin
            if (accept) begin
              cur_ch <= bus.out_ch;
              state  <= BEAT1;
            end
          end
          BEAT1: begin
            if (accept) begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (load) begin
        bus.out_cmd_type <= ld_half[CMD_LO +: 2*CMD_TYPE_WIDTH];
        bus.out_row      <= ld_half[ROW_LO +: 2*ROW_ADDR_WIDTH];
        bus.out_col      <= ld_half[COL_LO +: 2*COL_ADDR_WIDTH];
        bus.out_ba       <= ld_half[BA_LO  +: 2*BA_ADDR_WIDTH];
        bus.out_pc       <= ld_half[PC_LO  +: 2*PC_WIDTH];
        bus.out_wdata    <= ld_wd;
      end
    end
  end
endmodule

// File: tb/tb_hbm_cmd_unpacker.sv
// Directed bench: FIFO model per DUT, beat scoreboard, gap/latency/stall/reset/wrap checks.
module tb_hbm_cmd_unpacker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hbm_cmd_unpacker_if ia ();
  hbm_cmd_unpacker_if ib ();

  hbm_cmd_unpacker #(.CH_SWITCH_GAP(4)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  hbm_cmd_unpacker #(.CH_SWITCH_GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  typedef struct {
    logic [127:0]  d;
    logic [1023:0] w;
  } ent_t;

  ent_t         fq_a[$];
  ent_t         fq_b[$];
  logic [316:0] exp_a[$];
  int           pop_cycs[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_pop = 0, n_vld = 0;
  int last_pop = 0, first_vld = 0, last_vld = 0;
  int last_pop_b = 0, first_vld_b = 0;
  logic [2:0]   ch_b;
  logic         pop_a, pop_b;
  logic         prev_stall = 1'b0, prev_vld = 1'b0, prev_vld_b = 1'b0;
  logic [316:0] prev_obs;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Half layout MSB->LSB: ch{1,0}, pc{1,0}, ba{1,0}, col{1,0}, row{1,0}, cmd{1,0}
  function automatic logic [63:0] mk_half(input logic [2:0] ch, input logic [3:0] c0,
                                          input logic [3:0] c1, input logic [13:0] r0,
                                          input logic [13:0] r1);
    return {3'd7, ch, 2'b10, 8'hA5, 12'h3C1, r1, r0, c1, c0};
  endfunction

  task automatic drive();
    ia.fifo_empty  = (fq_a.size() == 0);
    ia.fifo_data   = (fq_a.size() != 0) ? fq_a[0].d : '0;
    ia.fifo_wrdata = (fq_a.size() != 0) ? fq_a[0].w : '0;
    ib.fifo_empty  = (fq_b.size() == 0);
    ib.fifo_data   = (fq_b.size() != 0) ? fq_b[0].d : '0;
    ib.fifo_wrdata = (fq_b.size() != 0) ? fq_b[0].w : '0;
  endtask

  // Upper {RD=1, ACT=2}, lower {NOP=F, PRE=3}; lower ch fields deliberately differ.
  task automatic push(input bit to_b, input logic [2:0] ch, input logic [13:0] rb);
    ent_t e;
    logic [63:0]  hi, lo;
    logic [511:0] wd;
    hi = mk_half(ch, 4'h1, 4'h2, rb, rb + 14'd1);
    lo = mk_half(~ch, 4'hF, 4'h3, rb + 14'd2, rb + 14'd3);
    for (int k = 0; k < 16; k++) wd[k*32 +: 32] = {rb, 2'b01, 16'(k * 4369)};
    e.d = {hi, lo};
    e.w = {~wd, wd};
    if (to_b) begin
      fq_b.push_back(e);
    end else begin
      fq_a.push_back(e);
      exp_a.push_back({hi[7:0], hi[35:8], hi[47:36], hi[55:48], hi[57:56], ch, wd[255:0]});
      exp_a.push_back({lo[7:0], lo[35:8], lo[47:36], lo[55:48], lo[57:56], ch, wd[511:256]});
    end
    drive();
  endtask

  task automatic tick();
    logic [316:0] obs;
    @(negedge clk);
    obs = {ia.out_cmd_type, ia.out_row, ia.out_col, ia.out_ba, ia.out_pc, ia.out_ch,
           ia.out_wdata};
    if (prev_stall) begin
      chk("stall_vld", ia.out_valid, 1);
      chk("stall_hold", obs, prev_obs);
    end
    if (ia.out_valid && !prev_vld) first_vld = cyc;
    if (ia.out_valid) begin
      n_vld++;
      last_vld = cyc;
    end
    if (ia.out_valid && ia.out_ready) begin
      if (exp_a.size() == 0) chk("beat_unexpected", exp_a.size(), 1);
      else chk("beat", obs, exp_a.pop_front());
    end
    pop_a = ia.fifo_rd_en;
    if (pop_a) begin
      n_pop++;
      last_pop = cyc;
      pop_cycs.push_back(cyc);
    end
    prev_stall = ia.out_valid && !ia.out_ready;
    prev_vld   = ia.out_valid;
    prev_obs   = obs;
    pop_b = ib.fifo_rd_en;
    if (pop_b) last_pop_b = cyc;
    if (ib.out_valid && !prev_vld_b) begin
      first_vld_b = cyc;
      ch_b = ib.out_ch;
    end
    prev_vld_b = ib.out_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_a && fq_a.size() != 0) void'(fq_a.pop_front());
    if (pop_b && fq_b.size() != 0) void'(fq_b.pop_front());
    drive();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_a.size() != 0 || fq_a.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk(tag, exp_a.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int p0;
    rst = 1'b1;
    ia.out_ready = 1'b0;
    ib.out_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", ia.out_valid, 0);
    chk("rst_cmd", ia.out_cmd_type, 8'hFF);
    chk("rst_row", ia.out_row, 0);
    chk("rst_cnt", ia.beat_cnt, 0);
    chk("rst_rd_en", ia.fifo_rd_en, 0);
    rst = 1'b0;
    ia.out_ready = 1'b1;

    // Single entry, channel 0: no gap, one pop, two beats
    p0 = n_pop;
    push(0, 3'd0, 14'd100);
    drain("t1_drain");
    chk("t1_pops", n_pop - p0, 1);
    chk("t1_lat", first_vld - last_pop, 1);
    chk("t1_cnt", ia.beat_cnt, 2);

    // Three back-to-back entries on channel 0
    pop_cycs.delete();
    n_vld = 0;
    push(0, 3'd0, 14'd200);
    push(0, 3'd0, 14'd210);
    push(0, 3'd0, 14'd220);
    drain("t2_drain");
    chk("t2_vld_cycles", n_vld, 6);
    chk("t2_vld_span", last_vld - first_vld, 5);
    chk("t2_npops", pop_cycs.size(), 3);
    if (pop_cycs.size() == 3) begin
      chk("t2_pop1", pop_cycs[1] - pop_cycs[0], 2);
      chk("t2_pop2", pop_cycs[2] - pop_cycs[0], 4);
    end
    chk("t2_cnt", ia.beat_cnt, 8);

    // Channel 0 -> 5: four idle cycles with gap 4, none with gap 0
    push(0, 3'd5, 14'd300);
    push(1, 3'd5, 14'd300);
    drain("t3_drain");
    chk("t3_gap_lat", first_vld - last_pop, 5);
    chk("t3_nogap_lat", first_vld_b - last_pop_b, 1);
    chk("t3_nogap_ch", ch_b, 5);
    chk("t3_cnt", ia.beat_cnt, 10);

    // Backpressure for 3 cycles in BEAT0 and in BEAT1
    push(0, 3'd5, 14'd400);
    push(0, 3'd5, 14'd410);
    tick();
    chk("t4_pop_first", pop_a, 1);
    ia.out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t4_nopop_b0", pop_a, 0);
    end
    ia.out_ready = 1'b1;
    tick();
    ia.out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t4_nopop_b1", pop_a, 0);
    end
    ia.out_ready = 1'b1;
    tick();
    chk("t4_pop_second", pop_a, 1);
    drain("t4_drain");
    chk("t4_cnt", ia.beat_cnt, 14);

    // Reset while in BEAT1 with the FIFO still holding an entry
    push(0, 3'd5, 14'd500);
    push(0, 3'd5, 14'd510);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_vld", ia.out_valid, 0);
    chk("t5_cmd", ia.out_cmd_type, 8'hFF);
    chk("t5_wdata", ia.out_wdata, 0);
    chk("t5_cnt", ia.beat_cnt, 0);
    void'(exp_a.pop_front());
    prev_stall = 1'b0;
    repeat (2) begin
      tick();
      chk("t5_nopop_rst", pop_a, 0);
    end
    rst = 1'b0;
    drain("t5_drain");
    chk("t5_gap_lat", first_vld - last_pop, 5);
    chk("t5_cnt_after", ia.beat_cnt, 2);

    // beat_cnt wrap
    force ia.beat_cnt = 32'hFFFF_FFFF;
    #1;
    release ia.beat_cnt;
    chk("t6_forced", ia.beat_cnt, 32'hFFFF_FFFF);
    push(0, 3'd5, 14'd600);
    tick();
    tick();
    chk("t6_wrap", ia.beat_cnt, 0);
    drain("t6_drain");
    chk("t6_cnt", ia.beat_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
